// File: rtl/interrupt_sequencer_if.sv
// Signals between the interrupt sequencer and the control unit, CAR latch and peripherals.
interface interrupt_sequencer_if #(
  parameter int unsigned NUM_IRQ = 8
);
  logic               swReset;
  logic               nmiIn;
  logic [NUM_IRQ-1:0] irqIn;
  logic               GIE;
  logic               INTACK;
  logic               resetSeq;
  logic               INTREQ;
  logic [15:0]        INTVEC;
  logic [NUM_IRQ-1:0] irqClr;
  logic               busy;

  modport master (
    input  swReset, nmiIn, irqIn, GIE, INTACK,
    output resetSeq, INTREQ, INTVEC, irqClr, busy
  );

  modport slave (
    output swReset, nmiIn, irqIn, GIE, INTACK,
    input  resetSeq, INTREQ, INTVEC, irqClr, busy
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Reset / interrupt request sequencer feeding the CAR latch: reset hold, NMI capture,
// fixed-priority maskable arbitration and vector presentation until the vector fetch is acked.
module interrupt_sequencer #(
  parameter int unsigned NUM_IRQ  = 8,
  parameter logic [15:0] VEC_BASE = 16'hFFE0,
  parameter logic [15:0] NMI_VEC  = 16'hFFFC,
  parameter logic [15:0] RST_VEC  = 16'hFFFE,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  interrupt_sequencer_if.master bus
);
  localparam int unsigned      IDX_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned      CNT_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {S_RST_HOLD, S_RST_WAIT, S_IDLE, S_REQ} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               nmi_s1, nmi_s2, nmi_s3;
  logic               nmi_pend, nmi_pend_d;
  logic               win_nmi, win_nmi_d;
  logic [IDX_W-1:0]   win_idx, win_idx_d;
  logic               reset_seq_q, reset_seq_d;
  logic               intreq_q, intreq_d;
  logic [15:0]        vec_q, vec_d;
  logic [NUM_IRQ-1:0] clr_q, clr_d;
  logic               busy_q, busy_d;

  logic               irq_hit;
  logic [IDX_W-1:0]   irq_idx;
  logic [15:0]        irq_vec;
  logic               take_irq;
  logic               nmi_edge;

  // Highest set index wins; later loop iterations override lower ones.
  always_comb begin
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (bus.irqIn[i]) begin
        irq_hit = 1'b1;
        irq_idx = IDX_W'(i);
      end
    end
  end

  assign irq_vec  = VEC_BASE + 16'({irq_idx, 1'b0});
  assign take_irq = bus.GIE & irq_hit;
  assign nmi_edge = nmi_s2 & ~nmi_s3;

  // State register plus all datapath and output flops; swReset replays the reset values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_RST_HOLD;
      cnt         <= CNT_INIT;
      nmi_s1      <= 1'b0;
      nmi_s2      <= 1'b0;
      nmi_s3      <= 1'b0;
      nmi_pend    <= 1'b0;
      win_nmi     <= 1'b0;
      win_idx     <= '0;
      reset_seq_q <= 1'b1;
      intreq_q    <= 1'b0;
      vec_q       <= RST_VEC;
      clr_q       <= '0;
      busy_q      <= 1'b1;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      nmi_s1      <= bus.swReset ? 1'b0 : bus.nmiIn;
      nmi_s2      <= bus.swReset ? 1'b0 : nmi_s1;
      nmi_s3      <= bus.swReset ? 1'b0 : nmi_s2;
      nmi_pend    <= nmi_pend_d;
      win_nmi     <= win_nmi_d;
      win_idx     <= win_idx_d;
      reset_seq_q <= reset_seq_d;
      intreq_q    <= intreq_d;
      vec_q       <= vec_d;
      clr_q       <= clr_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      S_RST_HOLD: if (cnt == '0) state_d = S_RST_WAIT;
      S_RST_WAIT: if (bus.INTACK) state_d = S_IDLE;
      S_IDLE:     if (nmi_pend || take_irq) state_d = S_REQ;
      S_REQ:      if (bus.INTACK) state_d = S_IDLE;
      default:    state_d = S_RST_HOLD;
    endcase
    if (bus.swReset) state_d = S_RST_HOLD;
  end

  // Output and datapath next values; outputs are decoded from the next state so they leave a flop.
  always_comb begin
    cnt_d      = cnt;
    nmi_pend_d = nmi_pend;
    win_nmi_d  = win_nmi;
    win_idx_d  = win_idx;
    vec_d      = vec_q;
    clr_d      = '0;
    case (state)
      S_RST_HOLD: if (cnt != '0) cnt_d = cnt - CNT_W'(1);
      S_IDLE: begin
        if (nmi_pend) begin
          win_nmi_d = 1'b1;
          vec_d     = NMI_VEC;
        end else if (take_irq) begin
          win_nmi_d = 1'b0;
          win_idx_d = irq_idx;
          vec_d     = irq_vec;
        end
      end
      S_REQ: begin
        if (bus.INTACK) begin
          if (win_nmi) nmi_pend_d = 1'b0;
          else         clr_d[win_idx] = 1'b1;
        end else if (nmi_pend && !win_nmi) begin
          win_nmi_d = 1'b1;
          vec_d     = NMI_VEC;
        end
      end
      default: ;
    endcase
    // A fresh edge wins over a same-cycle ack so the new NMI is not lost.
    if (nmi_edge && state != S_RST_HOLD) nmi_pend_d = 1'b1;
    if (bus.swReset) begin
      cnt_d      = CNT_INIT;
      nmi_pend_d = 1'b0;
      win_nmi_d  = 1'b0;
      win_idx_d  = '0;
      vec_d      = RST_VEC;
      clr_d      = '0;
    end
    reset_seq_d = (state_d == S_RST_HOLD);
    intreq_d    = (state_d == S_REQ);
    busy_d      = (state_d != S_IDLE);
  end

  assign bus.resetSeq = reset_seq_q;
  assign bus.INTREQ   = intreq_q;
  assign bus.INTVEC   = vec_q;
  assign bus.irqClr   = clr_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: expected vector/clear pairs are queued as requests
// are stimulated and compared when the sequencer presents and retires them.
module tb_interrupt_sequencer;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   hi_cnt;

  typedef struct {
    logic [15:0] vec;
    logic [7:0]  clr;
  } exp_t;
  exp_t sb[$];

  interrupt_sequencer_if #(.NUM_IRQ(8)) bus ();

  interrupt_sequencer #(
    .NUM_IRQ (8),
    .VEC_BASE(16'hFFE0),
    .NMI_VEC (16'hFFFC),
    .RST_VEC (16'hFFFE),
    .RST_HOLD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] vec, input logic [7:0] clr);
    exp_t e;
    e.vec = vec;
    e.clr = clr;
    sb.push_back(e);
  endtask

  task automatic sb_vec(input string tag);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed vec=%0h expected=<none queued>", tag, bus.INTVEC);
    end else begin
      chk(tag, 32'(bus.INTVEC), 32'(sb[0].vec));
    end
  endtask

  task automatic sb_retire(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed clr=%0h expected=<none queued>", tag, bus.irqClr);
    end else begin
      e = sb.pop_front();
      chk(tag, 32'(bus.irqClr), 32'(e.clr));
    end
  endtask

  // Wait (bounded) for INTREQ, check the vector, ack it and check the retire pulse.
  task automatic serve(input string tag);
    int n = 0;
    while (bus.INTREQ !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(bus.INTREQ), 32'd1);
    sb_vec({tag, "_vec"});
    bus.INTACK = 1'b1;
    tick();
    bus.INTACK = 1'b0;
    sb_retire({tag, "_clr"});
    chk({tag, "_drop"}, 32'(bus.INTREQ), 32'd0);
  endtask

  initial begin
    bus.swReset = 1'b0;
    bus.nmiIn   = 1'b0;
    bus.irqIn   = 8'h00;
    bus.GIE     = 1'b0;
    bus.INTACK  = 1'b0;
    rst         = 1'b1;
    #1 rst      = 1'b0;
    tick();
    tick();
    chk("rst_resetSeq", 32'(bus.resetSeq), 32'd1);
    chk("rst_intreq",   32'(bus.INTREQ),   32'd0);
    chk("rst_vec",      32'(bus.INTVEC),   32'hFFFE);
    chk("rst_clr",      32'(bus.irqClr),   32'h0);
    chk("rst_busy",     32'(bus.busy),     32'd1);

    // 1: reset hold length, then ack in RST_WAIT
    rst    = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.resetSeq) hi_cnt++;
      tick();
    end
    chk("hold_cycles", 32'(hi_cnt),         32'd4);
    chk("wait_vec",    32'(bus.INTVEC),     32'hFFFE);
    chk("wait_busy",   32'(bus.busy),       32'd1);
    bus.INTACK = 1'b1;
    tick();
    bus.INTACK = 1'b0;
    chk("idle_busy",   32'(bus.busy),       32'd0);
    bus.INTACK = 1'b1;
    tick();
    bus.INTACK = 1'b0;
    chk("idle_ack_ignored", 32'(bus.INTREQ), 32'd0);

    // 2: maskable priority, one-cycle gap, next source
    bus.GIE   = 1'b1;
    bus.irqIn = 8'b0010_0100;
    push(16'hFFEA, 8'b0010_0000);
    tick();
    chk("t2_latency", 32'(bus.INTREQ), 32'd1);
    serve("t2_irq5");
    bus.irqIn = 8'b0000_0100;
    push(16'hFFE4, 8'b0000_0100);
    tick();
    chk("t2_gap1", 32'(bus.INTREQ), 32'd1);
    serve("t2_irq2");
    bus.irqIn = 8'h00;
    tick();

    // 3: NMI with GIE=0, captured and requested 4 cycles after the pin rises
    bus.GIE   = 1'b0;
    bus.irqIn = 8'hFF;
    bus.nmiIn = 1'b1;
    tick();
    tick();
    tick();
    chk("t3_not_yet", 32'(bus.INTREQ), 32'd0);
    push(16'hFFFC, 8'h00);
    tick();
    chk("t3_cycle4", 32'(bus.INTREQ), 32'd1);
    serve("t3_nmi");
    tick();
    tick();
    chk("t3_pend_cleared", 32'(bus.INTREQ), 32'd0);
    bus.nmiIn = 1'b0;
    bus.irqIn = 8'h00;
    for (int i = 0; i < 4; i++) tick();

    // 4: NMI upgrades a pending maskable request, irq3 comes back afterwards
    bus.GIE   = 1'b1;
    bus.irqIn = 8'b0000_1000;
    tick();
    chk("t4_irq3_vec", 32'(bus.INTVEC), 32'hFFE6);
    bus.nmiIn = 1'b1;
    tick();
    bus.nmiIn = 1'b0;
    tick();
    tick();
    chk("t4_pre_upgrade", 32'(bus.INTVEC), 32'hFFE6);
    push(16'hFFFC, 8'h00);
    tick();
    serve("t4_upgrade");
    push(16'hFFE6, 8'b0000_1000);
    serve("t4_irq3_again");
    bus.irqIn = 8'h00;
    for (int i = 0; i < 4; i++) tick();

    // 5: ack of irq1 coincides with a synchronized NMI edge
    bus.irqIn = 8'b0000_0010;
    push(16'hFFE2, 8'b0000_0010);
    tick();
    sb_vec("t5_irq1_vec");
    bus.nmiIn = 1'b1;
    tick();
    tick();
    bus.INTACK = 1'b1;
    tick();
    bus.INTACK = 1'b0;
    sb_retire("t5_irq1_clr");
    chk("t5_gap", 32'(bus.INTREQ), 32'd0);
    bus.irqIn = 8'h00;
    push(16'hFFFC, 8'h00);
    tick();
    chk("t5_nmi_req", 32'(bus.INTREQ), 32'd1);
    serve("t5_nmi");
    bus.nmiIn = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // 6a: swReset with a simultaneous ack
    bus.irqIn = 8'b0001_0000;
    tick();
    chk("t6_irq4_vec", 32'(bus.INTVEC), 32'hFFE8);
    bus.INTACK  = 1'b1;
    bus.swReset = 1'b1;
    tick();
    bus.INTACK  = 1'b0;
    bus.swReset = 1'b0;
    bus.irqIn   = 8'h00;
    chk("t6_clr",    32'(bus.irqClr),   32'h0);
    chk("t6_intreq", 32'(bus.INTREQ),   32'd0);
    chk("t6_vec",    32'(bus.INTVEC),   32'hFFFE);
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.resetSeq) hi_cnt++;
      tick();
    end
    chk("t6_hold_cycles", 32'(hi_cnt), 32'd4);
    bus.INTACK = 1'b1;
    tick();
    bus.INTACK = 1'b0;
    chk("t6_idle_busy", 32'(bus.busy), 32'd0);

    // 6b: asynchronous reset in the middle of a request
    bus.irqIn = 8'b0000_0001;
    push(16'hFFE0, 8'h01);
    tick();
    sb_vec("t6_irq0_vec");
    sb.delete();
    #2 rst = 1'b0;
    #1;
    chk("t6_async_intreq", 32'(bus.INTREQ),   32'd0);
    chk("t6_async_clr",    32'(bus.irqClr),   32'h0);
    chk("t6_async_rseq",   32'(bus.resetSeq), 32'd1);
    tick();
    rst       = 1'b1;
    bus.irqIn = 8'h00;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
Produces the reset and interrupt-request controls that steer the CAR latch: a reset pulse that forces the no-push interrupt sequence (CAR_INT4), and a held INTREQ that diverts the next fetch or branch into the push sequence (CAR_INT0). It latches NMI and maskable requests and arbitrates them by fixed priority. It presents the winning vector address and retires the request when the control unit acknowledges the vector fetch. It sits between peripheral interrupt lines and the control unit / CAR latch logic.

Parameters:
NUM_IRQ, 8, number of maskable sources; index NUM_IRQ-1 has the highest priority.
VEC_BASE, 16'hFFE0, vector address of maskable source 0; source i uses VEC_BASE + 2*i.
NMI_VEC, 16'hFFFC, NMI vector address.
RST_VEC, 16'hFFFE, reset vector address.
RST_HOLD, 4, number of cycles resetSeq stays high after reset release (at least 1).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset.
swReset  input  1  synchronous PUC request (watchdog, etc.), active-high.
nmiIn  input  1  asynchronous NMI pin; rising edge is significant.
irqIn  input  NUM_IRQ  level-sensitive maskable requests.
GIE  input  1  status register global interrupt enable.
INTACK  input  1  one-cycle pulse from the control unit when the vector fetch completes.
resetSeq  output  1  drives the CAR latch rst input.
INTREQ  output  1  drives the CAR latch INTREQ input.
INTVEC  output  16  vector address for the current request.
irqClr  output  NUM_IRQ  one-cycle clear pulse to the serviced source.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- States: RST_HOLD, RST_WAIT, IDLE, REQ.
- While rst=0: state=RST_HOLD; cnt=RST_HOLD-1; resetSeq=1; INTREQ=0; INTVEC=RST_VEC; irqClr=0; nmiPend=0; NMI synchronizer flops=0; busy=1.
- RST_HOLD: resetSeq=1. cnt decrements each cycle. At cnt==0, go to RST_WAIT. resetSeq is therefore high for exactly RST_HOLD clocks after rst rises.
- RST_WAIT: resetSeq=0, INTVEC=RST_VEC. On INTACK, go to IDLE.
- NMI detection: nmiIn passes through a 2-flop synchronizer plus one edge flop. A synchronized 0->1 edge sets nmiPend in any state except RST_HOLD. It is captured 3 cycles after the pin rises. Edges during RST_HOLD are discarded.
- IDLE, evaluated each cycle:
  - If nmiPend: winner=NMI, INTVEC=NMI_VEC.
  - Else if GIE and |irqIn: winner = highest set index i, INTVEC = VEC_BASE + 2*i (16-bit add, no wrap check).
  - When a winner is found, INTREQ=1 and state=REQ on the next edge.
- REQ:
  - INTREQ is held at 1 until INTACK.
  - A maskable winner stays frozen even if irqIn[i] or GIE drops; there is no withdrawal.
  - If nmiPend becomes set while the winner is maskable and INTACK=0, the winner upgrades to NMI and INTVEC changes to NMI_VEC on the next edge.
  - On INTACK: next edge INTREQ=0, state=IDLE. For a maskable winner, irqClr[i]=1 for exactly that cycle. For an NMI winner, nmiPend is cleared.
  - If a new NMI edge and INTACK coincide, the ack retires the current winner and nmiPend stays set. The NMI is then requested from IDLE one cycle later.
- INTACK in IDLE is ignored.
- Minimum gap between consecutive requests: one IDLE cycle, so INTREQ shows a low pulse of at least 1 cycle.
- swReset=1 in any state: next edge takes the rst-asserted values, then the normal RST_HOLD count. swReset overrides a simultaneous INTACK. A pending NMI is dropped.
- Async rst mid-REQ: INTREQ falls immediately (asynchronously), with no irqClr.
- busy = (state != IDLE).

Test Plan:
1. Release rst at cycle 0 -> resetSeq=1 for exactly 4 cycles with INTVEC=16'hFFFE. INTACK in RST_WAIT -> IDLE, busy=0.
2. GIE=1, irqIn=8'b0010_0100 -> INTREQ=1 next cycle, INTVEC=16'hFFEA. INTACK -> irqClr=8'b0010_0000 pulse, INTREQ=0. After the source clears bit5, INTVEC=16'hFFE4 one IDLE cycle later.
3. GIE=0, irqIn=8'hFF, nmiIn rising -> INTREQ=1 at cycle 4, INTVEC=16'hFFFC. INTACK clears nmiPend. No irqClr pulse.
4. In REQ with winner irq3 (INTVEC=16'hFFE6), pulse nmiIn, no INTACK -> INTVEC becomes 16'hFFFC. INTACK -> nmiPend cleared, irqClr=0. irq3 is then requested again from IDLE.
5. Winner irq1 with INTACK in the same cycle as a synchronized NMI edge -> irqClr[1] pulses, INTREQ=0 for one cycle, then INTREQ=1 with INTVEC=16'hFFFC.
6. swReset=1 while in REQ alongside INTACK -> no irqClr, INTREQ=0, resetSeq=1 for 4 cycles. Async rst pulse mid-REQ -> INTREQ=0 without waiting for a clock edge.
